// File: rtl/trap_ctrl_pipe.sv
// Precise-trap controller: priority cause select, pipeline flush
// sequencing, handler redirect and trap return.
module trap_ctrl_pipe #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NCAUSE       = 5,
    parameter logic [31:0] HANDLER_PC   = 32'h74,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCAUSE-1:0]      cause_vld,
    input  logic [NCAUSE*XLEN-1:0] cause_pc,
    input  logic                   ret_req,
    input  logic                   trap_en,
    output logic                   flush_o,
    output logic                   redirect_vld,
    output logic [XLEN-1:0]        redirect_pc,
    output logic [XLEN-1:0]        spec,
    output logic [NCAUSE-1:0]      scause,
    output logic                   in_trap,
    output logic                   double_fault,
    output logic [7:0]             trap_cnt
);

    localparam int unsigned SW = (NCAUSE > 1) ? $clog2(NCAUSE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        REDIR,
        HANDLER,
        RET
    } state_t;

    state_t state, state_nxt;

    logic [NCAUSE-1:0] req;
    logic              any_req;
    logic [SW-1:0]     sel;
    logic [NCAUSE-1:0] sel_oh;
    logic [XLEN-1:0]   sel_pc;
    logic [3:0]        fcnt;

    assign req     = cause_vld & {NCAUSE{trap_en}};
    assign any_req = |req;

    // Walk downwards so the lowest set index wins.
    always_comb begin
        sel    = '0;
        sel_oh = '0;
        for (int i = NCAUSE - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel    = SW'(i);
                sel_oh = NCAUSE'(1) << i;
            end
        end
    end

    assign sel_pc = cause_pc[sel*XLEN +: XLEN];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        flush_o      = 1'b0;
        redirect_vld = 1'b0;
        redirect_pc  = '0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                flush_o = 1'b1;
                if (fcnt == 4'd0) begin
                    state_nxt = REDIR;
                end
            end
            REDIR: begin
                redirect_vld = 1'b1;
                redirect_pc  = XLEN'(HANDLER_PC);
                state_nxt    = HANDLER;
            end
            HANDLER: begin
                if (ret_req) begin
                    state_nxt = RET;
                end
            end
            RET: begin
                redirect_vld = 1'b1;
                redirect_pc  = spec + XLEN'(4);
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec         <= '0;
            scause       <= '0;
            in_trap      <= 1'b0;
            double_fault <= 1'b0;
            trap_cnt     <= '0;
            fcnt         <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                spec    <= sel_pc;
                scause  <= sel_oh;
                in_trap <= 1'b1;
                fcnt    <= 4'(FLUSH_CYCLES - 1);
                if (trap_cnt != 8'hFF) begin
                    trap_cnt <= trap_cnt + 8'd1;
                end
            end
            if (state == FLUSH && fcnt != 4'd0) begin
                fcnt <= fcnt - 4'd1;
            end
            if (state == HANDLER) begin
                if (any_req) begin
                    double_fault <= 1'b1;
                end
                // Drop in_trap as the return redirect is issued.
                if (ret_req) begin
                    in_trap <= 1'b0;
                end
            end
        end
    end

endmodule
